// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC math units: degree-based arctangent table,
// rotation gain, quadrant-fold angles and FSM state encodings.
package cordic_pkg;

  localparam int ATAN_N = 38;

  // atan(2^-i) in degrees, Q9.31 (value * 2^31), rounded to nearest
  localparam logic signed [39:0] ATAN_TAB [0:ATAN_N-1] = '{
    40'sd96636764160, 40'sd57048013011, 40'sd30142603327, 40'sd15300856101,
    40'sd7680119590,  40'sd3843803763,  40'sd1922370905,  40'sd961244113,
    40'sd480629390,   40'sd240315612,   40'sd120157920,   40'sd60078975,
    40'sd30039489,    40'sd15019745,    40'sd7509872,     40'sd3754936,
    40'sd1877468,     40'sd938734,      40'sd469367,      40'sd234684,
    40'sd117342,      40'sd58671,       40'sd29335,       40'sd14668,
    40'sd7334,        40'sd3667,        40'sd1833,        40'sd917,
    40'sd458,         40'sd229,         40'sd115,         40'sd57,
    40'sd29,          40'sd14,          40'sd7,           40'sd4,
    40'sd2,           40'sd1
  };

  // 1/prod(sqrt(1+2^-2i)) in Q2.30 (0.6072529350)
  localparam logic signed [31:0] CORDIC_K = 32'sh26DD3B6A;

  localparam logic signed [39:0] DEG_90  = 40'sd193273528320;
  localparam logic signed [39:0] DEG_180 = 40'sd386547056640;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_ROT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cordic_sincos_if.sv
// Start/done handshake and result bus of the iterative sin/cos CORDIC.
interface cordic_sincos_if;
  logic               start;
  logic signed [31:0] angle;
  logic               busy;
  logic               done;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;

  modport master (output start, angle, input busy, done, cos_out, sin_out);
  modport slave  (input start, angle, output busy, done, cos_out, sin_out);
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, index -> atan(2^-idx) in Q9.31 degrees.
module cordic_atan_rom (
  input  logic [5:0]         idx,
  output logic signed [39:0] atan
);
  import cordic_pkg::*;

  always_comb begin
    atan = '0;
    if (idx < 6'(ATAN_N)) atan = ATAN_TAB[idx];
  end
endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, angle in
// (Q9.23 degrees), cos/sin out (Q2.30) with a start/done handshake.
module cordic_sincos #(
  parameter int ITER = 30,
  parameter int XW   = 34,
  parameter int ZW   = 40
) (
  input logic            clk,
  input logic            rst_n,
  cordic_sincos_if.slave bus
);
  import cordic_pkg::*;

  localparam logic [5:0]          LAST   = 6'(ITER - 1);
  localparam logic signed [XW:0]  SAT_HI = (XW + 1)'(64'sd1073741824);
  localparam logic signed [ZW-1:0] Z_90  = ZW'(DEG_90);
  localparam logic signed [ZW-1:0] Z_180 = ZW'(DEG_180);

  logic [1:0]            state;
  logic [5:0]            cnt;
  logic signed [XW-1:0]  x, y;
  logic signed [ZW-1:0]  z;
  logic                  neg;
  logic signed [31:0]    angle_q;
  logic                  busy_q, done_q;
  logic signed [31:0]    cos_q, sin_q;

  logic signed [ZW-1:0]  z_in, z_fold, z_nxt, atan_z;
  logic                  neg_fold;
  logic signed [39:0]    atan_val;
  logic                  d;
  logic signed [XW-1:0]  x_sh, y_sh, x_nxt, y_nxt;

  // Clamp to +/-1.0 after optional negation; the extra bit keeps -x exact.
  function automatic logic signed [31:0] sat32(input logic signed [XW-1:0] v, input logic n);
    logic signed [XW:0] w;
    w = n ? -((XW + 1)'(v)) : (XW + 1)'(v);
    if (w > SAT_HI) w = SAT_HI;
    else if (w < -SAT_HI) w = -SAT_HI;
    return w[31:0];
  endfunction

  cordic_atan_rom u_rom (
    .idx  (cnt),
    .atan (atan_val)
  );

  assign atan_z = ZW'(atan_val);
  assign z_in   = $signed({angle_q, {(ZW - 32){1'b0}}});

  // Fold into [-90,+90]; the +/-90 boundaries stay unfolded.
  always_comb begin
    z_fold   = z_in;
    neg_fold = 1'b0;
    if (z_in > Z_90) begin
      z_fold   = z_in - Z_180;
      neg_fold = 1'b1;
    end else if (z_in < -Z_90) begin
      z_fold   = z_in + Z_180;
      neg_fold = 1'b1;
    end
  end

  always_comb begin
    d    = ~z[ZW-1];
    x_sh = x >>> cnt;
    y_sh = y >>> cnt;
    if (d) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_z;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      neg     <= 1'b0;
      angle_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            angle_q <= bus.angle;
            busy_q  <= 1'b1;
            state   <= ST_PREP;
          end
        end
        ST_PREP: begin
          x     <= XW'(CORDIC_K);
          y     <= '0;
          z     <= z_fold;
          neg   <= neg_fold;
          cnt   <= '0;
          state <= ST_ROT;
        end
        ST_ROT: begin
          x   <= x_nxt;
          y   <= y_nxt;
          z   <= z_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          cos_q  <= sat32(x, neg);
          sin_q  <= sat32(y, neg);
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;

  angle_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE && bus.start) |-> (bus.angle >= -32'sh5A000000 && bus.angle <= 32'sh5A000000));

endmodule
